// File: rtl/bimodal_btb_predictor.sv
// Direct-mapped BTB with 2-bit saturating direction counters and saturating
// hit / mispredict statistics. Lookup is combinational; training is registered.
module bimodal_btb_predictor #(
    parameter int unsigned ENTRIES    = 16,
    parameter int unsigned STAT_WIDTH = 32
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [31:0]           current_pc,
    input  logic                  is_rv32c,
    input  logic                  is_branch,
    input  logic                  is_jump,
    input  logic [12:0]           imm_sb,
    input  logic [31:0]           instr,
    input  logic                  update_predictor,
    input  logic [31:0]           pc_to_update,
    input  logic [31:0]           update_addr,
    input  logic                  branch_result,
    input  logic                  prediction,
    input  logic                  direction,
    output logic                  predict_taken,
    output logic [31:0]           target_addr,
    output logic [STAT_WIDTH-1:0] hit_count,
    output logic [STAT_WIDTH-1:0] mispredict_count
);

    localparam int unsigned IW = $clog2(ENTRIES);
    localparam int unsigned TW = 31 - IW;

    logic          valid_q  [ENTRIES];
    logic [TW-1:0] tag_q    [ENTRIES];
    logic [31:0]   target_q [ENTRIES];
    logic [1:0]    ctr_q    [ENTRIES];

    logic [STAT_WIDTH-1:0] hit_cnt_q, hit_cnt_d;
    logic [STAT_WIDTH-1:0] misp_cnt_q, misp_cnt_d;

    // Bit 0 of both PCs is always zero for halfword-aligned code.
    logic unused_inputs;
    assign unused_inputs = ^{imm_sb, instr, direction, current_pc[0], pc_to_update[0]};

    logic [IW-1:0] rd_idx;
    logic [TW-1:0] rd_tag;
    logic          rd_hit;

    assign rd_idx = current_pc[IW:1];
    assign rd_tag = current_pc[31:IW+1];
    assign rd_hit = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);

    assign predict_taken = rd_hit && (is_jump || (is_branch && ctr_q[rd_idx][1]));
    assign target_addr   = predict_taken ? target_q[rd_idx]
                                         : current_pc + (is_rv32c ? 32'd2 : 32'd4);

    logic [IW-1:0] wr_idx;
    logic [TW-1:0] wr_tag;
    logic          wr_hit;
    logic          wr_en;
    logic [1:0]    wr_ctr_d;
    logic [31:0]   wr_target_d;

    assign wr_idx = pc_to_update[IW:1];
    assign wr_tag = pc_to_update[31:IW+1];
    assign wr_hit = valid_q[wr_idx] && (tag_q[wr_idx] == wr_tag);

    always_comb begin
        wr_en       = 1'b0;
        wr_ctr_d    = ctr_q[wr_idx];
        wr_target_d = target_q[wr_idx];
        if (update_predictor) begin
            if (wr_hit) begin
                wr_en = 1'b1;
                if (branch_result) begin
                    wr_ctr_d    = (ctr_q[wr_idx] == 2'b11) ? 2'b11 : ctr_q[wr_idx] + 2'b01;
                    wr_target_d = update_addr;
                end else begin
                    wr_ctr_d = (ctr_q[wr_idx] == 2'b00) ? 2'b00 : ctr_q[wr_idx] - 2'b01;
                end
            end else if (branch_result) begin
                // Allocate on a taken miss, starting weakly taken.
                wr_en       = 1'b1;
                wr_ctr_d    = 2'b10;
                wr_target_d = update_addr;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= 2'b01;
            end
        end else if (wr_en) begin
            valid_q[wr_idx]  <= 1'b1;
            tag_q[wr_idx]    <= wr_tag;
            target_q[wr_idx] <= wr_target_d;
            ctr_q[wr_idx]    <= wr_ctr_d;
        end
    end

    always_comb begin
        hit_cnt_d  = hit_cnt_q;
        misp_cnt_d = misp_cnt_q;
        if (rd_hit && (is_branch || is_jump) && (hit_cnt_q != '1)) begin
            hit_cnt_d = hit_cnt_q + STAT_WIDTH'(1);
        end
        if (update_predictor && (prediction != branch_result) && (misp_cnt_q != '1)) begin
            misp_cnt_d = misp_cnt_q + STAT_WIDTH'(1);
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            hit_cnt_q  <= '0;
            misp_cnt_q <= '0;
        end else begin
            hit_cnt_q  <= hit_cnt_d;
            misp_cnt_q <= misp_cnt_d;
        end
    end

    assign hit_count        = hit_cnt_q;
    assign mispredict_count = misp_cnt_q;

endmodule

// File: tb/tb_bimodal_btb_predictor.sv
// Directed bench for bimodal_btb_predictor; a second instance with 4-bit
// statistics shares all inputs to exercise counter saturation.
module tb_bimodal_btb_predictor;

    logic        CLK = 1'b0;
    logic        RST;
    logic [31:0] current_pc;
    logic        is_rv32c, is_branch, is_jump;
    logic [12:0] imm_sb;
    logic [31:0] instr;
    logic        update_predictor;
    logic [31:0] pc_to_update, update_addr;
    logic        branch_result, prediction, direction;
    logic        predict_taken;
    logic [31:0] target_addr;
    logic [31:0] hit_count, mispredict_count;
    logic        pt4;
    logic [31:0] tgt4;
    logic [3:0]  hit4, misp4;

    int checks = 0;
    int errors = 0;
    int exp_misp = 0;
    int exp_hits = 0;

    always #5 CLK = ~CLK;

    bimodal_btb_predictor dut (
        .CLK(CLK), .RST(RST), .current_pc(current_pc), .is_rv32c(is_rv32c),
        .is_branch(is_branch), .is_jump(is_jump), .imm_sb(imm_sb), .instr(instr),
        .update_predictor(update_predictor), .pc_to_update(pc_to_update),
        .update_addr(update_addr), .branch_result(branch_result),
        .prediction(prediction), .direction(direction),
        .predict_taken(predict_taken), .target_addr(target_addr),
        .hit_count(hit_count), .mispredict_count(mispredict_count)
    );

    bimodal_btb_predictor #(.ENTRIES(16), .STAT_WIDTH(4)) dut4 (
        .CLK(CLK), .RST(RST), .current_pc(current_pc), .is_rv32c(is_rv32c),
        .is_branch(is_branch), .is_jump(is_jump), .imm_sb(imm_sb), .instr(instr),
        .update_predictor(update_predictor), .pc_to_update(pc_to_update),
        .update_addr(update_addr), .branch_result(branch_result),
        .prediction(prediction), .direction(direction),
        .predict_taken(pt4), .target_addr(tgt4),
        .hit_count(hit4), .mispredict_count(misp4)
    );

    task automatic lk(input logic [31:0] pc, input logic br, input logic jmp, input logic c);
        current_pc = pc;
        is_branch  = br;
        is_jump    = jmp;
        is_rv32c   = c;
        #1;
    endtask

    task automatic idle();
        is_branch = 1'b0;
        is_jump   = 1'b0;
        is_rv32c  = 1'b0;
    endtask

    task automatic upd(input logic [31:0] pc, input logic [31:0] addr,
                       input logic res, input logic pred);
        @(negedge CLK);
        update_predictor = 1'b1;
        pc_to_update     = pc;
        update_addr      = addr;
        branch_result    = res;
        prediction       = pred;
        if (pred != res) exp_misp++;
        @(negedge CLK);
        update_predictor = 1'b0;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        update_predictor = 1'b0; pc_to_update = '0; update_addr = '0;
        branch_result = 1'b0; prediction = 1'b0; direction = 1'b0;
        imm_sb = '0; instr = '0;
        lk(32'h100, 1'b1, 1'b0, 1'b0);
        repeat (2) @(negedge CLK);
        #1;
        checks++;
        if (predict_taken !== 1'b0 || target_addr !== 32'h104) begin
            errors++;
            $display("FAIL in_reset: pt=%0b tgt=%h, want pt=0 tgt=00000104", predict_taken, target_addr);
        end
        @(negedge CLK);
        RST = 1'b0;
        lk(32'h100, 1'b1, 1'b0, 1'b0);
        checks++;
        if (predict_taken !== 1'b0 || target_addr !== 32'h104) begin
            errors++;
            $display("FAIL post_reset_lookup: pt=%0b tgt=%h, want pt=0 tgt=00000104", predict_taken, target_addr);
        end
        lk(32'h100, 1'b1, 1'b0, 1'b1);
        checks++;
        if (target_addr !== 32'h102) begin
            errors++;
            $display("FAIL post_reset_rv32c: tgt=%h, want 00000102", target_addr);
        end
        checks++;
        if (hit_count !== 32'd0 || mispredict_count !== 32'd0) begin
            errors++;
            $display("FAIL reset_stats: hits=%0d misp=%0d, want 0 0", hit_count, mispredict_count);
        end
        idle();
    endtask

    task automatic test_train();
        upd(32'h100, 32'h80, 1'b1, 1'b0);
        lk(32'h100, 1'b1, 1'b0, 1'b0);
        checks++;
        if (predict_taken !== 1'b1 || target_addr !== 32'h80) begin
            errors++;
            $display("FAIL alloc: pt=%0b tgt=%h, want pt=1 tgt=00000080", predict_taken, target_addr);
        end
        checks++;
        if (mispredict_count !== 32'd1) begin
            errors++;
            $display("FAIL misp_first: got %0d, want 1", mispredict_count);
        end
        idle();
        upd(32'h100, 32'h300, 1'b0, 1'b1);
        lk(32'h100, 1'b1, 1'b0, 1'b0);
        checks++;
        if (predict_taken !== 1'b0 || target_addr !== 32'h104) begin
            errors++;
            $display("FAIL ctr_1: pt=%0b tgt=%h, want pt=0 tgt=00000104", predict_taken, target_addr);
        end
        idle();
        upd(32'h100, 32'h300, 1'b0, 1'b0);
        upd(32'h100, 32'h80, 1'b1, 1'b0);
        lk(32'h100, 1'b1, 1'b0, 1'b0);
        checks++;
        if (predict_taken !== 1'b0) begin
            errors++;
            $display("FAIL ctr_0_to_1: pt=%0b, want 0", predict_taken);
        end
        idle();
        upd(32'h100, 32'h80, 1'b1, 1'b0);
        lk(32'h100, 1'b1, 1'b0, 1'b0);
        checks++;
        if (predict_taken !== 1'b1) begin
            errors++;
            $display("FAIL ctr_1_to_2: pt=%0b, want 1", predict_taken);
        end
        idle();
        upd(32'h100, 32'h80, 1'b1, 1'b0);
        upd(32'h100, 32'h80, 1'b1, 1'b0);
        upd(32'h100, 32'h300, 1'b0, 1'b1);
        lk(32'h100, 1'b1, 1'b0, 1'b0);
        checks++;
        if (predict_taken !== 1'b1 || target_addr !== 32'h80) begin
            errors++;
            $display("FAIL ctr_sat_3: pt=%0b tgt=%h, want pt=1 tgt=00000080", predict_taken, target_addr);
        end
        idle();
        upd(32'h100, 32'h300, 1'b0, 1'b1);
        lk(32'h100, 1'b1, 1'b0, 1'b0);
        checks++;
        if (predict_taken !== 1'b0) begin
            errors++;
            $display("FAIL ctr_back_to_1: pt=%0b, want 0", predict_taken);
        end
        lk(32'h100, 1'b0, 1'b1, 1'b0);
        checks++;
        if (predict_taken !== 1'b1 || target_addr !== 32'h80) begin
            errors++;
            $display("FAIL jump_hit: pt=%0b tgt=%h, want pt=1 tgt=00000080", predict_taken, target_addr);
        end
        idle();
        checks++;
        if (mispredict_count !== 32'(exp_misp)) begin
            errors++;
            $display("FAIL misp_train: got %0d, want %0d", mispredict_count, exp_misp);
        end
    endtask

    task automatic test_alias();
        upd(32'h100, 32'h80, 1'b1, 1'b1);
        lk(32'h120, 1'b1, 1'b0, 1'b0);
        checks++;
        if (predict_taken !== 1'b0 || target_addr !== 32'h124) begin
            errors++;
            $display("FAIL alias_miss: pt=%0b tgt=%h, want pt=0 tgt=00000124", predict_taken, target_addr);
        end
        idle();
        upd(32'h120, 32'h40, 1'b0, 1'b0);
        lk(32'h100, 1'b1, 1'b0, 1'b0);
        checks++;
        if (predict_taken !== 1'b1 || target_addr !== 32'h80) begin
            errors++;
            $display("FAIL no_alloc_nt: pt=%0b tgt=%h, want pt=1 tgt=00000080", predict_taken, target_addr);
        end
        idle();
        upd(32'h120, 32'h40, 1'b1, 1'b0);
        lk(32'h120, 1'b1, 1'b0, 1'b0);
        checks++;
        if (predict_taken !== 1'b1 || target_addr !== 32'h40) begin
            errors++;
            $display("FAIL alias_alloc: pt=%0b tgt=%h, want pt=1 tgt=00000040", predict_taken, target_addr);
        end
        lk(32'h100, 1'b1, 1'b0, 1'b0);
        checks++;
        if (predict_taken !== 1'b0 || target_addr !== 32'h104) begin
            errors++;
            $display("FAIL alias_evict: pt=%0b tgt=%h, want pt=0 tgt=00000104", predict_taken, target_addr);
        end
        idle();
    endtask

    task automatic test_back_to_back();
        upd(32'h100, 32'h80, 1'b1, 1'b0);
        update_predictor = 1'b1;
        pc_to_update     = 32'h100;
        update_addr      = 32'h200;
        branch_result    = 1'b1;
        prediction       = 1'b1;
        lk(32'h100, 1'b1, 1'b0, 1'b0);
        checks++;
        if (predict_taken !== 1'b1 || target_addr !== 32'h80) begin
            errors++;
            $display("FAIL same_cycle_old: pt=%0b tgt=%h, want pt=1 tgt=00000080", predict_taken, target_addr);
        end
        exp_hits++;
        @(negedge CLK);
        update_predictor = 1'b0;
        #1;
        checks++;
        if (predict_taken !== 1'b1 || target_addr !== 32'h200) begin
            errors++;
            $display("FAIL same_cycle_new: pt=%0b tgt=%h, want pt=1 tgt=00000200", predict_taken, target_addr);
        end
        checks++;
        if (hit_count !== 32'(exp_hits)) begin
            errors++;
            $display("FAIL hit_count_one: got %0d, want %0d", hit_count, exp_hits);
        end
        idle();
        lk(32'h100, 1'b0, 1'b0, 1'b0);
        checks++;
        if (predict_taken !== 1'b0 || target_addr !== 32'h104) begin
            errors++;
            $display("FAIL no_hint: pt=%0b tgt=%h, want pt=0 tgt=00000104", predict_taken, target_addr);
        end
        @(negedge CLK);
        #1;
        checks++;
        if (hit_count !== 32'(exp_hits)) begin
            errors++;
            $display("FAIL hit_no_hint: got %0d, want %0d", hit_count, exp_hits);
        end
    endtask

    task automatic test_wrap();
        lk(32'hFFFF_FFFE, 1'b1, 1'b0, 1'b0);
        checks++;
        if (predict_taken !== 1'b0 || target_addr !== 32'h2) begin
            errors++;
            $display("FAIL wrap_4: pt=%0b tgt=%h, want pt=0 tgt=00000002", predict_taken, target_addr);
        end
        lk(32'hFFFF_FFFE, 1'b1, 1'b0, 1'b1);
        checks++;
        if (target_addr !== 32'h0) begin
            errors++;
            $display("FAIL wrap_2: tgt=%h, want 00000000", target_addr);
        end
        idle();
    endtask

    task automatic test_async_reset();
        @(negedge CLK);
        lk(32'h100, 1'b1, 1'b0, 1'b0);
        #2;
        RST = 1'b1;
        #1;
        checks++;
        if (predict_taken !== 1'b0 || target_addr !== 32'h104) begin
            errors++;
            $display("FAIL async_rst_pt: pt=%0b tgt=%h, want pt=0 tgt=00000104", predict_taken, target_addr);
        end
        checks++;
        if (hit_count !== 32'd0 || mispredict_count !== 32'd0) begin
            errors++;
            $display("FAIL async_rst_stats: hits=%0d misp=%0d, want 0 0", hit_count, mispredict_count);
        end
        idle();
        exp_hits = 0;
        exp_misp = 0;
        @(negedge CLK);
        RST              = 1'b0;
        update_predictor = 1'b1;
        pc_to_update     = 32'h100;
        update_addr      = 32'h500;
        branch_result    = 1'b1;
        prediction       = 1'b1;
        @(negedge CLK);
        update_predictor = 1'b0;
        lk(32'h100, 1'b1, 1'b0, 1'b0);
        checks++;
        if (predict_taken !== 1'b1 || target_addr !== 32'h500) begin
            errors++;
            $display("FAIL rst_release_upd: pt=%0b tgt=%h, want pt=1 tgt=00000500", predict_taken, target_addr);
        end
        idle();
    endtask

    task automatic test_stat_sat();
        for (int i = 0; i < 17; i++) upd(32'h140, 32'h0, 1'b0, 1'b1);
        #1;
        checks++;
        if (misp4 !== 4'd15 || mispredict_count !== 32'(exp_misp)) begin
            errors++;
            $display("FAIL misp_sat: w4=%0d w32=%0d, want 15 %0d", misp4, mispredict_count, exp_misp);
        end
        lk(32'h100, 1'b0, 1'b1, 1'b0);
        repeat (17) @(negedge CLK);
        idle();
        exp_hits += 17;
        #1;
        checks++;
        if (hit4 !== 4'd15 || hit_count !== 32'(exp_hits)) begin
            errors++;
            $display("FAIL hit_sat: w4=%0d w32=%0d, want 15 %0d", hit4, hit_count, exp_hits);
        end
        checks++;
        if (misp4 !== 4'd15) begin
            errors++;
            $display("FAIL misp_hold: w4=%0d, want 15", misp4);
        end
    endtask

    initial begin
        test_reset();
        test_train();
        test_alias();
        test_back_to_back();
        test_wrap();
        test_async_reset();
        test_stat_sat();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bimodal_btb_predictor.md
Name: bimodal_btb_predictor

Overview:
- Direct-mapped branch target buffer with per-entry 2-bit saturating counters; implements the predictor side of the branch-predictor/pipeline interface.
- Fetch presents current_pc and decode hints; the block returns predict_taken and target_addr in the same cycle.
- Execute resolves branches and trains the table through the update port.
- Also keeps saturating hit and mispredict statistics counters for performance monitoring.

Parameters:
ENTRIES, 16, number of BTB entries; power of two, at least 2.
STAT_WIDTH, 32, width of each statistics counter.

Ports:
CLK  input  1  system clock; all state updates on the rising edge
RST  input  1  asynchronous, active-high reset
current_pc  input  32  fetch PC to predict
is_rv32c  input  1  fetched instruction is 16-bit compressed
is_branch  input  1  fetched instruction is a conditional branch
is_jump  input  1  fetched instruction is JAL/JALR
imm_sb  input  13  branch immediate; unused for prediction, reserved
instr  input  32  fetched instruction word; unused, reserved
update_predictor  input  1  training strobe from execute
pc_to_update  input  32  PC of the resolved branch
update_addr  input  32  resolved target address
branch_result  input  1  resolved outcome, 1 = taken
prediction  input  1  prediction that was made for this branch
direction  input  1  unused, reserved
predict_taken  output  1  predict redirect
target_addr  output  32  predicted next PC
hit_count  output  STAT_WIDTH  lookups that hit with is_branch|is_jump
mispredict_count  output  STAT_WIDTH  updates where prediction != branch_result

Behaviour:
- Index = pc[IW:1], where IW = log2(ENTRIES). Tag = pc[31:IW+1]. Halfword granularity, so RV32C branches are supported.
- Each entry holds: valid, tag, 32-bit target, 2-bit counter.
- Lookup is purely combinational on current_pc.
  - hit = valid && tag match.
  - predict_taken = hit && ((is_jump) || (is_branch && ctr[1])).
  - When is_branch = is_jump = 0, predict_taken = 0.
  - target_addr = predict_taken ? entry.target : current_pc + (is_rv32c ? 2 : 4), using 32-bit wrap-around arithmetic.
- Update is registered, one write per cycle, applied on the rising CLK edge when update_predictor = 1, using pc_to_update's index and tag.
  - Tag hit, taken: ctr = min(ctr+1, 3); target <= update_addr.
  - Tag hit, not taken: ctr = max(ctr-1, 0); target unchanged.
  - Miss or invalid, taken: allocate by overwriting the entry. valid = 1, tag written, target = update_addr, ctr = 2'b10 (weakly taken).
  - Miss, not taken: no allocation; table unchanged.
- Same-cycle lookup and update to the same index: the lookup sees pre-update contents. The new contents are visible from the next cycle.
- Statistics:
  - hit_count increments on the edge when hit && (is_branch || is_jump).
  - mispredict_count increments on the edge when update_predictor && (prediction != branch_result).
  - Both saturate at all-ones and never wrap.
- Reset (asynchronous, any time, including mid-update): all valid = 0, all ctr = 2'b01, targets and tags = 0, both statistics counters = 0.
  - During and immediately after reset: predict_taken = 0 and target_addr = current_pc + 4/2.
  - An update coincident with reset deassertion follows the normal edge rule (RST low at the edge means the write occurs).
- Latency: prediction 0 cycles; training effect visible 1 cycle after the update edge.
- No stalls or handshake; update_predictor is a single-cycle strobe, one update per asserted cycle.

Test Plan:
- Reset, then current_pc=0x100, is_branch=1 -> predict_taken=0, target_addr=0x104; with is_rv32c=1 -> target_addr=0x102; hit_count=0.
- Update pc_to_update=0x100, branch_result=1, update_addr=0x80, prediction=0 -> next cycle lookup of 0x100 (is_branch) gives predict_taken=1, target_addr=0x80, ctr=2; mispredict_count=1.
- Two not-taken updates to 0x100 -> ctr 2→1→0; predict_taken=0. Four taken updates -> ctr saturates at 3. One not-taken update -> ctr=2, still taken.
- Alias: train 0x100 taken, then lookup 0x120 (same index with ENTRIES=16, different tag) -> miss, target_addr=0x124. Taken update at 0x120 with update_addr=0x40 overwrites the entry; 0x100 now misses.
- Same-cycle lookup and update to 0x100 (taken, new target 0x200) -> that cycle outputs the old target 0x80; next cycle outputs 0x200.
- Assert RST asynchronously mid-cycle with entries valid -> predict_taken drops to 0 immediately and counters clear. Force statistics near all-ones with STAT_WIDTH=4 -> counters hold at 15.
